// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned NUM_PORTS = 2;

    typedef logic [0:0] port_id_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    // Byte address to word index, wrapping modulo depth (depth is a power of 2).
    function automatic int unsigned word_idx(input logic [31:0] addr, input int unsigned depth);
        return (addr >> 2) & (depth - 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side request/response bus plus the memory-macro side of the arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 32
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [31:0]       req_wdata0;
    logic [31:0]       req_wdata1;
    logic [3:0]        req_be0;
    logic [3:0]        req_be1;

    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_en;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;

    // Arbiter view.
    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_be0, req_be1, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

    // Requesters plus memory macro view.
    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output req_be0, req_be1, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/rr_burst_arb.sv
// Two-port round-robin arbiter with a bounded burst hold; owns last_grant and burst_cnt.
module rr_burst_arb
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req_valid,
    output logic [NUM_PORTS-1:0] grant
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    port_id_t         last_grant_q;
    logic [CNT_W-1:0] burst_cnt_q;
    port_id_t         winner;

    // A zero count means no burst is in progress, so a tie goes to the port that did not
    // win last; this is what makes port 0 win the first tie out of reset.
    always_comb begin
        grant = '0;
        unique case (req_valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (burst_cnt_q != '0 && burst_cnt_q < CNT_W'(MAX_BURST)) begin
                    grant[last_grant_q] = 1'b1;
                end else begin
                    grant[~last_grant_q] = 1'b1;
                end
            end
            default: grant = '0;
        endcase
    end

    assign winner = port_id_t'(grant[1]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= port_id_t'(1'b1);
            burst_cnt_q  <= '0;
        end else if (grant != '0) begin
            if (winner == last_grant_q) begin
                if (burst_cnt_q < CNT_W'(MAX_BURST)) begin
                    burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                end
            end else begin
                last_grant_q <= winner;
                burst_cnt_q  <= CNT_W'(1);
            end
        end else begin
            burst_cnt_q <= '0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a synchronous-read data memory.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned requests with rsp_err instead of accessing memory.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [NUM_PORTS-1:0] grant;
    port_id_t             sel;
    mem_req_t             req;
    logic                 xfer;
    logic                 misalign;

    logic [NUM_PORTS-1:0] rsp_valid_q;
    logic                 rsp_load_q;
    logic                 rsp_err_q;

    rr_burst_arb #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_valid (bus.req_valid),
        .grant     (grant)
    );

    assign bus.req_ready = grant;
    assign xfer          = |grant;
    assign sel           = port_id_t'(grant[1]);

    always_comb begin
        req.we = bus.req_we[sel];
        if (sel == port_id_t'(1'b1)) begin
            req.addr  = 32'(bus.req_addr1);
            req.wdata = bus.req_wdata1;
            req.be    = bus.req_be1;
        end else begin
            req.addr  = 32'(bus.req_addr0);
            req.wdata = bus.req_wdata0;
            req.be    = bus.req_be0;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = xfer &&
                      ((req.be == 4'hF && req.addr[1:0] != 2'b00) ||
                       ((req.be == 4'h3 || req.be == 4'hC) && req.addr[0]));
`else
    assign misalign = 1'b0;
`endif

    assign bus.mem_en    = xfer & ~misalign;
    assign bus.mem_we    = bus.mem_en & req.we;
    assign bus.mem_addr  = IDX_W'(word_idx(req.addr, DEPTH));
    assign bus.mem_wdata = req.wdata;
    assign bus.mem_be    = req.be;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= '0;
            rsp_load_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= grant;
            rsp_load_q  <= xfer & ~req.we & ~misalign;
            rsp_err_q   <= misalign;
        end
    end

    // Read data arrives from the macro in the response cycle; gating keeps it zero otherwise.
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_load_q ? bus.mem_rdata : 32'h0;
    assign bus.rsp_err   = rsp_err_q;

endmodule
